// File: rtl/alu_seq.sv
// Sequential signed ALU: single-cycle add/sub/logic, iterative WIDTH-cycle
// multiply (shift-add) and divide (restoring) behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         sel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               z_f,
  output logic               o_f,
  output logic               dz_f,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  logic               r_is_div, w_is_div_next;
  logic               r_neg, w_neg_next;
  logic               r_a_neg, w_a_neg_next;
  logic [WIDTH:0]     r_hi, w_hi_next;
  logic [WIDTH-1:0]   r_lo, w_lo_next;
  logic [WIDTH:0]     r_mb, w_mb_next;
  logic [2*WIDTH-1:0] r_result, w_result_next;
  logic               r_z, w_z_next;
  logic               r_o, w_o_next;
  logic               r_dz, w_dz_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;

  // Operand magnitudes; |MIN| = 2^(WIDTH-1) fits as unsigned.
  logic [WIDTH:0]     w_a_mag, w_b_mag;
  logic [WIDTH-1:0]   w_add, w_sub;
  logic               w_add_ovf, w_sub_ovf;
  logic [WIDTH+1:0]   w_mul_sum;
  logic [WIDTH:0]     w_rem_sh, w_rem_diff;
  logic [2*WIDTH-1:0] w_mul_mag, w_prod;
  logic               w_prod_ovf;
  logic [WIDTH-1:0]   w_quot, w_rem;
  logic               w_div_ovf;

  assign w_a_mag = {1'b0, a[WIDTH-1] ? (~a + 1'b1) : a};
  assign w_b_mag = {1'b0, b[WIDTH-1] ? (~b + 1'b1) : b};

  assign w_add     = a + b;
  assign w_sub     = a - b;
  assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
  assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);

  // Multiply step: conditionally add multiplicand to the high half, shift right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : {(WIDTH+2){1'b0}});

  // Divide step: shift next dividend bit into the partial remainder, try subtract.
  assign w_rem_sh   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - r_mb;

  assign w_mul_mag  = {r_hi[WIDTH-1:0], r_lo};
  assign w_prod     = r_neg ? (~w_mul_mag + 1'b1) : w_mul_mag;
  assign w_prod_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
  assign w_quot     = r_neg ? (~r_lo + 1'b1) : r_lo;
  assign w_rem      = r_a_neg ? (~r_hi[WIDTH-1:0] + 1'b1) : r_hi[WIDTH-1:0];
  // A non-negated quotient with its top bit set only arises from MIN / -1.
  assign w_div_ovf  = !r_neg && r_lo[WIDTH-1];

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_is_div_next = r_is_div;
    w_neg_next    = r_neg;
    w_a_neg_next  = r_a_neg;
    w_hi_next     = r_hi;
    w_lo_next     = r_lo;
    w_mb_next     = r_mb;
    w_result_next = r_result;
    w_z_next      = r_z;
    w_o_next      = r_o;
    w_dz_next     = r_dz;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && sel != OP_NOP) begin
          case (sel)
            OP_ADD: begin
              w_result_next = {{WIDTH{w_add[WIDTH-1]}}, w_add};
              w_o_next = w_add_ovf; w_dz_next = 1'b0; w_done_next = 1'b1;
            end
            OP_SUB: begin
              w_result_next = {{WIDTH{w_sub[WIDTH-1]}}, w_sub};
              w_o_next = w_sub_ovf; w_dz_next = 1'b0; w_done_next = 1'b1;
            end
            OP_AND: begin
              w_result_next = {{WIDTH{1'b0}}, a & b};
              w_o_next = 1'b0; w_dz_next = 1'b0; w_done_next = 1'b1;
            end
            OP_OR: begin
              w_result_next = {{WIDTH{1'b0}}, a | b};
              w_o_next = 1'b0; w_dz_next = 1'b0; w_done_next = 1'b1;
            end
            OP_XOR: begin
              w_result_next = {{WIDTH{1'b0}}, a ^ b};
              w_o_next = 1'b0; w_dz_next = 1'b0; w_done_next = 1'b1;
            end
            default: begin
              if (sel == OP_DIV && b == '0) begin
                w_result_next = {a, {WIDTH{1'b1}}};
                w_o_next = 1'b1; w_dz_next = 1'b1; w_done_next = 1'b1;
              end else begin
                w_state_next  = S_CALC;
                w_busy_next   = 1'b1;
                w_cnt_next    = CNT_LAST;
                w_is_div_next = (sel == OP_DIV);
                w_neg_next    = a[WIDTH-1] ^ b[WIDTH-1];
                w_a_neg_next  = a[WIDTH-1];
                w_hi_next     = '0;
                w_lo_next     = w_a_mag[WIDTH-1:0];
                w_mb_next     = w_b_mag;
              end
            end
          endcase
        end
      end
      S_CALC: begin
        if (r_is_div) begin
          if (w_rem_sh >= r_mb) begin
            w_hi_next = w_rem_diff;
            w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            w_hi_next = w_rem_sh;
            w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          w_hi_next = w_mul_sum[WIDTH+1:1];
          w_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
        w_cnt_next = r_cnt - 1'b1;
        if (r_cnt == '0) w_state_next = S_FIX;
      end
      S_FIX: begin
        if (r_is_div) begin
          w_result_next = {w_rem, w_quot};
          w_o_next      = w_div_ovf;
        end else begin
          w_result_next = w_prod;
          w_o_next      = w_prod_ovf;
        end
        w_dz_next    = 1'b0;
        w_done_next  = 1'b1;
        w_busy_next  = 1'b0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_done_next) w_z_next = ~|w_result_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_a_neg  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mb     <= '0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_o      <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_is_div <= w_is_div_next;
      r_neg    <= w_neg_next;
      r_a_neg  <= w_a_neg_next;
      r_hi     <= w_hi_next;
      r_lo     <= w_lo_next;
      r_mb     <= w_mb_next;
      r_result <= w_result_next;
      r_z      <= w_z_next;
      r_o      <= w_o_next;
      r_dz     <= w_dz_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
    end
  end

  assign result = r_result;
  assign z_f    = r_z;
  assign o_f    = r_o;
  assign dz_f   = r_dz;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table on a 32-bit instance, hand sequences
// for reset abort, nop, held start, and an 8-bit instance multiply.
module tb_alu_seq;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  sel;
  logic [31:0] a, b;
  logic [63:0] result;
  logic        z_f, o_f, dz_f, busy, done;

  logic        start8;
  logic [2:0]  sel8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;
  logic        z8, o8, dz8, busy8, done8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .a(a), .b(b),
    .result(result), .z_f(z_f), .o_f(o_f), .dz_f(dz_f), .busy(busy), .done(done)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8), .a(a8), .b(b8),
    .result(result8), .z_f(z8), .o_f(o8), .dz_f(dz8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        z;
    logic        o;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one op on the 32-bit instance; lat = edges from accept to the done edge.
  task automatic do_op(input logic [2:0] s, input logic [31:0] va, input logic [31:0] vb,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; sel = s; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0; sel = OP_NOP;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dones;
    vecs[0]  = '{OP_ADD, 32'd12,        -32'sd12,     64'h0000000000000000, 1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{OP_ADD, 32'h70000000, 32'h70000000, 64'hFFFFFFFFE0000000, 1'b0, 1'b1, 1'b0, 0};
    vecs[2]  = '{OP_SUB, 32'd6,         32'd6,        64'h0000000000000000, 1'b1, 1'b0, 1'b0, 0};
    vecs[3]  = '{OP_SUB, 32'd5,         32'd7,        64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{OP_SUB, 32'h80000000, 32'd1,        64'h000000007FFFFFFF, 1'b0, 1'b1, 1'b0, 0};
    vecs[5]  = '{OP_MUL, -32'sd12,      32'd4,        64'hFFFFFFFFFFFFFFD0, 1'b0, 1'b0, 1'b0, 33};
    vecs[6]  = '{OP_MUL, 32'h70000000, 32'd2,        64'h00000000E0000000, 1'b0, 1'b1, 1'b0, 33};
    vecs[7]  = '{OP_MUL, 32'd4,         32'd0,        64'h0000000000000000, 1'b1, 1'b0, 1'b0, 33};
    vecs[8]  = '{OP_MUL, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, 1'b1, 1'b0, 33};
    vecs[9]  = '{OP_DIV, -32'sd13,      32'd4,        64'hFFFFFFFFFFFFFFFD, 1'b0, 1'b0, 1'b0, 33};
    vecs[10] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000, 1'b0, 1'b1, 1'b0, 33};
    vecs[11] = '{OP_DIV, 32'd4,         32'd0,        64'h00000004FFFFFFFF, 1'b0, 1'b1, 1'b1, 0};
    vecs[12] = '{OP_DIV, 32'd100,       32'd7,        64'h000000020000000E, 1'b0, 1'b0, 1'b0, 33};
    vecs[13] = '{OP_AND, 32'hFFFFFFFF, 32'hAAAAAAAA, 64'h00000000AAAAAAAA, 1'b0, 1'b0, 1'b0, 0};
    vecs[14] = '{OP_OR,  32'h55555555, 32'hAAAAAAAA, 64'h00000000FFFFFFFF, 1'b0, 1'b0, 1'b0, 0};
    vecs[15] = '{OP_DIV, 32'd7,         -32'sd2,      64'h00000001FFFFFFFD, 1'b0, 1'b0, 1'b0, 33};

    rst_n = 1'b0; start = 1'b0; sel = OP_NOP; a = '0; b = '0;
    start8 = 1'b0; sel8 = OP_NOP; a8 = '0; b8 = '0;
    #12;
    check("reset_outputs", {result, z_f, o_f, dz_f, busy, done}, '0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, lat, bcnt);
      $display("op %0d sel=%b a=%h b=%h -> result=%h z=%b o=%b dz=%b lat=%0d busy=%0d",
               i, vecs[i].sel, vecs[i].a, vecs[i].b, result, z_f, o_f, dz_f, lat, bcnt);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_flags", i), {61'd0, z_f, o_f, dz_f},
            {61'd0, vecs[i].z, vecs[i].o, vecs[i].dz});
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
    end

    // xor of equal operands, then a nop that must leave everything untouched
    do_op(OP_XOR, 32'h12345678, 32'h12345678, lat, bcnt);
    $display("op xor equal -> result=%h z=%b lat=%0d", result, z_f, lat);
    check("xor_eq_z", {63'd0, z_f}, 64'd1);
    @(negedge clk); start = 1'b1; sel = OP_NOP; a = 32'd1; b = 32'd2;
    @(posedge clk); #1; start = 1'b0;
    $display("op nop -> done=%b busy=%b result=%h", done, busy, result);
    check("nop_no_done", {62'd0, done, busy}, 64'd0);
    check("nop_result_kept", {63'd0, z_f}, 64'd1);

    // Reset in the middle of a multiply aborts it
    do_op(OP_SUB, 32'd9, 32'd2, lat, bcnt);
    @(negedge clk); start = 1'b1; sel = OP_MUL; a = -32'sd12; b = 32'd4;
    @(posedge clk); #1; start = 1'b0; sel = OP_NOP;
    check("mid_op_busy", {63'd0, busy}, 64'd1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("op reset mid-mul -> result=%h busy=%b done=%b", result, busy, done);
    check("mid_op_reset_outputs", {result, z_f, o_f, dz_f, busy, done}, '0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("aborted_no_done", 64'(dones), 64'd0);
    do_op(OP_ADD, 32'd6, 32'd3, lat, bcnt);
    $display("op add 6+3 -> result=%h lat=%0d", result, lat);
    check("post_reset_add", result, 64'd9);
    check("post_reset_add_lat", 64'(lat), 64'd0);

    // start held through a divide: later requests ignored, one done only
    @(negedge clk); start = 1'b1; sel = OP_DIV; a = 32'd100; b = 32'd7;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin a = 32'd0; sel = OP_MUL; end
      if (done) begin dones++; start = 1'b0; sel = OP_NOP; end
    end
    start = 1'b0;
    $display("op div held start -> result=%h dones=%0d", result, dones);
    check("held_start_dones", 64'(dones), 64'd1);
    check("held_start_result", result, 64'h000000020000000E);

    // 8-bit instance: 127*127
    @(negedge clk); start8 = 1'b1; sel8 = OP_MUL; a8 = 8'd127; b8 = 8'd127;
    @(posedge clk); #1; start8 = 1'b0; sel8 = OP_NOP;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op w8 mul 127*127 -> result=%h o=%b lat=%0d", result8, o8, lat);
    check("w8_mul_result", {48'd0, result8}, 64'h3F01);
    check("w8_mul_ovf", {63'd0, o8}, 64'd1);
    check("w8_mul_latency", 64'(lat), 64'd9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational 32-bit ALU.
- Supports add, sub, and, or and xor as single-cycle ops.
- Multiply and divide are iterative and signed, running WIDTH cycles each.
- Uses a start/busy/done handshake so the processor control unit can stall on long ops; results and flags stay registered until the next accepted op.

Parameters:
- WIDTH, 32, operand width in bits (>=4); result is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- sel  input  3  opcode: 001 add, 010 sub, 011 mul, 100 div, 101 and, 110 or, 111 xor, 000 nop
- a  input  WIDTH  operand A, two's complement
- b  input  WIDTH  operand B, two's complement
- result  output  2*WIDTH  registered result
- z_f  output  1  result == 0 (all 2*WIDTH bits)
- o_f  output  1  signed overflow / invalid result
- dz_f  output  1  divide by zero
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse: result/flags updated

Behaviour:
- Reset (async, rst_n=0): state IDLE; result=0, z_f=0, o_f=0, dz_f=0, busy=0, done=0; internal counter and operand registers cleared.
- Reset during CALC aborts the op; no done is produced.
- Accept: rising edge with state IDLE, start=1 and sel!=000. a, b and sel are latched at that edge (edge E0).
- start while busy=1 is ignored (not queued).
- sel=000 with start=1: no state change, no done.
- States: IDLE -> (mul/div accepted) CALC -> FIX -> IDLE. Single-cycle ops stay in IDLE.
- Single-cycle ops (add, sub, and, or, xor, and div with b=0):
  - result and flags written at E0; done=1 for the cycle after E0; busy stays 0.
  - Back-to-back single ops are legal every cycle.
- Mul/div timing:
  - busy=1 from E0.
  - CALC runs WIDTH edges (E0+1 .. E0+WIDTH), one iteration per edge; counter counts WIDTH-1 down to 0.
  - FIX at edge E0+WIDTH+1: sign correction, result/flags written, done=1 and busy=0 from this edge for one cycle.
  - The next start is accepted at edge E0+WIDTH+1 or later; done of op N and acceptance of op N+1 may coincide.
- Add/sub:
  - s = a±b, WIDTH-bit wrap.
  - result = sign-extend(s) to 2*WIDTH.
  - o_f = signed overflow (operand signs match, for sub after negating b, and s sign differs).
- And/or/xor: result = zero-extend(a op b); o_f=0.
- Mul:
  - Shift-add on magnitudes |a|, |b| (|MIN| = 2^(WIDTH-1), held in WIDTH+1 bits).
  - Product negated in FIX if sign(a)^sign(b).
  - result = full 2*WIDTH signed product.
  - o_f=1 iff the product does not fit in WIDTH signed bits.
- Div:
  - Restoring division on magnitudes; truncation toward zero.
  - result[WIDTH-1:0] = quotient; result[2*WIDTH-1:WIDTH] = remainder; remainder sign = sign of a.
  - b=0: single-cycle; quotient all ones, remainder = a, dz_f=1, o_f=1.
  - a=MIN, b=-1: quotient=MIN, remainder=0, o_f=1.
  - Otherwise o_f=0.
- dz_f is cleared by any other completed op.
- z_f is computed on the final written result for every op.
- Flags and result are unchanged between done pulses.

Test Plan:
- Reset mid-op: assert rst_n=0 during a mul CALC -> outputs all 0 immediately (async), no done afterwards; then add 6+3 -> result=9, done 1 cycle after accept.
- Add/sub flags:
  - add 12+(-12) -> result=0, z_f=1.
  - add 0x70000000+0x70000000 -> result=0xFFFFFFFFE0000000, o_f=1.
  - sub 6-6 -> z_f=1.
- Mul, WIDTH=32:
  - -12*4 -> result=0xFFFFFFFFFFFFFFD0; done exactly 33 edges after accept; busy high 33 cycles.
  - 0x70000000*2 -> result=0xE0000000, o_f=1.
  - 4*0 -> z_f=1.
- Div:
  - -13/4 -> quotient=-3 (0xFFFFFFFD), remainder=-1.
  - 0x80000000/-1 -> o_f=1.
  - 4/0 -> single-cycle done, dz_f=1, result={0x00000004,0xFFFFFFFF}.
- Logic/handshake:
  - and 0xFFFFFFFF&0xAAAAAAAA -> 0xAAAAAAAA.
  - or 0x55555555|0xAAAAAAAA -> 0xFFFFFFFF.
  - xor equal operands -> z_f=1.
  - start held high during div -> extra requests ignored; exactly one done.
- Parameter: WIDTH=8, mul 127*127 -> result=0x3F01, o_f=1, done 9 edges after accept.
